// File: rtl/sopc_boutons_irq.sv
// Avalon-MM button PIO: two-flop sync, optional per-bit debounce (SOPC_BOUTONS_DEBOUNCE_EN),
// edge capture with write-1-to-clear, and a masked level interrupt.
module sopc_boutons_irq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE            = 1,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_V = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_val;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ec_q, ec_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_bits;

`ifdef SOPC_BOUTONS_DEBOUNCE_EN
    localparam int unsigned   CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            deb_q, deb_d;

    // Counter tracks how long sync2 has disagreed with deb; it stops at CNT_LAST so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int b = 0; b < WIDTH; b++) begin
            if (sync2_q[b] == deb_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
                deb_d[b] = sync2_q[b];
                cnt_d[b] = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            deb_q <= IDLE_V;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_val = deb_q;
`else
    assign deb_val = sync2_q;
`endif

    always_comb begin
        case (EDGE)
            32'd0:   edge_hit = deb_val & ~prev_q;
            32'd2:   edge_hit = deb_val ^ prev_q;
            default: edge_hit = ~deb_val & prev_q;
        endcase
    end

    // Register-file next state; a newly detected edge overrides a same-cycle clear.
    always_comb begin
        wr_en      = chipselect & ~write_n;
        clr_bits   = '0;
        mask_d     = mask_q;
        readdata_d = '0;
        if (wr_en && address == 2'd3) begin
            clr_bits = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        ec_d = (ec_q & ~clr_bits) | edge_hit;
        case (address)
            2'd0:    readdata_d = 32'(deb_val);
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(ec_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= IDLE_V;
            sync2_q    <= IDLE_V;
            prev_q     <= IDLE_V;
            mask_q     <= '0;
            ec_q       <= '0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            prev_q     <= deb_val;
            mask_q     <= mask_d;
            ec_q       <= ec_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata    = readdata_q;
    assign irq         = |(ec_q & mask_q);
    assign unused_bits = ^{writedata, 32'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_sopc_boutons_irq.sv
// Self-checking bench for sopc_boutons_irq: directed scenarios plus randomized traffic
// compared against a timestamp-based behavioural model.
module tb_sopc_boutons_irq;

    localparam int W = 4;
    localparam int N = 4;
`ifdef SOPC_BOUTONS_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int LAT = DEB ? N + 2 : 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    // Model state: synchroniser delay line, debounced level, last level, capture, mask.
    logic [W-1:0] m_s1, m_s2, m_deb, m_prev, m_ec, m_mask;
    logic [31:0]  m_rd;
    int           m_since [W];
    int           m_e = 0;

    sopc_boutons_irq #(
        .WIDTH(W), .DEBOUNCE_CYCLES(N), .EDGE(1), .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_deb = '1; m_prev = '1;
        m_ec = '0; m_mask = '0; m_rd = '0;
        for (int b = 0; b < W; b++) m_since[b] = m_e;
    endtask

    // A debounced bit adopts the synchronised level once that level has held, different
    // from the current debounced level, for N consecutive samples.
    task automatic model_edge();
        logic [W-1:0] d_eff, hit, clr, ec_n, deb_n;
        logic [31:0]  rd_n;
        logic         wr;
        m_e++;
        if (!reset_n) begin
            model_reset();
            return;
        end
        d_eff = DEB ? m_deb : m_s2;
        for (int b = 0; b < W; b++) hit[b] = (m_prev[b] == 1'b1) && (d_eff[b] == 1'b0);
        case (address)
            2'd0:    rd_n = {28'd0, d_eff};
            2'd2:    rd_n = {28'd0, m_mask};
            2'd3:    rd_n = {28'd0, m_ec};
            default: rd_n = 32'd0;
        endcase
        wr   = chipselect && !write_n;
        clr  = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        ec_n = (m_ec & ~clr) | hit;
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        deb_n = m_deb;
        for (int b = 0; b < W; b++)
            if (DEB && m_s2[b] != m_deb[b] && (m_e - 1 - m_since[b]) >= N - 1) deb_n[b] = m_s2[b];
        for (int b = 0; b < W; b++)
            if (m_s1[b] != m_s2[b]) m_since[b] = m_e;
        m_prev = d_eff;
        m_deb  = deb_n;
        m_s2   = m_s1;
        m_s1   = in_port;
        m_ec   = ec_n;
        m_rd   = rd_n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_readdata", readdata, m_rd);
        chk("model_irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_port = 4'hF;
        model_reset();
        #1;
        chk("async_reset_readdata", readdata, 32'd0);
        chk("async_reset_irq", {31'd0, irq}, 32'd0);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    initial begin
        int hold;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = 4'hF;
        model_reset();
        #2;
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("first_read_data", readdata, 32'h0000000F);
        address = 2'd3;
        tick();
        chk("reset_edgecapture", readdata, 32'd0);

        // Falling edge on bit0 with mask 1, then write-1-to-clear.
        bus_write(2'd2, 32'h1);
        address = 2'd0;
        in_port = 4'hE;
        repeat (LAT) tick();
        chk("pre_latency_irq", {31'd0, irq}, 32'd0);
        chk("pre_latency_data", readdata, 32'h0000000F);
        tick();
        chk("latency_irq", {31'd0, irq}, 32'd1);
        chk("latency_data", readdata, 32'h0000000E);
        address = 2'd3;
        tick();
        chk("ec_read", readdata, 32'h1);
        bus_write(2'd3, 32'h1);
        chk("clear_irq", {31'd0, irq}, 32'd0);
        tick();
        chk("clear_ec", readdata, 32'd0);

        // Short glitch on bit1.
        address = 2'd0;
        in_port = 4'hC;
        repeat (N - 1) tick();
        in_port = 4'hE;
        repeat (LAT + 3) tick();
`ifdef SOPC_BOUTONS_DEBOUNCE_EN
        chk("glitch_data", readdata, 32'h0000000E);
        address = 2'd3;
        tick();
        chk("glitch_ec", readdata, 32'd0);
        chk("glitch_irq", {31'd0, irq}, 32'd0);
`endif
        bus_write(2'd3, 32'hF);

        // Set wins over a coincident clear.
        in_port = 4'hF;
        repeat (LAT + 3) tick();
        in_port = 4'hE;
        repeat (LAT + 2) tick();
        in_port = 4'hF;
        repeat (LAT + 3) tick();
        address = 2'd3;
        tick();
        chk("ec_before_race", readdata, 32'h1);
        in_port = 4'hE;
        repeat (LAT) tick();
        bus_write(2'd3, 32'h1);
        address = 2'd3;
        tick();
        chk("set_wins_ec", readdata, 32'h1);
        chk("set_wins_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'hF);

        // Masked capture, then unmask.
        bus_write(2'd2, 32'h0);
        address = 2'd3;
        in_port = 4'hA;
        repeat (LAT + 2) tick();
        chk("masked_ec", readdata, 32'h4);
        chk("masked_irq", {31'd0, irq}, 32'd0);
        bus_write(2'd2, 32'h4);
        chk("unmask_irq", {31'd0, irq}, 32'd1);

        // Upper writedata bits ignored; reserved address reads zero.
        bus_write(2'd2, 32'hFFFF_FFF3);
        address = 2'd2;
        tick();
        chk("mask_width", readdata, 32'h3);
        bus_write(2'd1, 32'hFFFF_FFFF);
        address = 2'd1;
        tick();
        chk("reserved_read", readdata, 32'd0);

        // Reset mid-debounce with capture pending, then idle input must stay quiet.
        in_port = 4'h0;
        repeat (2) tick();
        do_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        address = 2'd3;
        repeat (LAT + 3) tick();
        chk("post_reset_ec", readdata, 32'd0);
        chk("post_reset_irq", {31'd0, irq}, 32'd0);
        address = 2'd0;
        tick();
        chk("post_reset_data", readdata, 32'h0000000F);

        // Randomized traffic against the model.
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                in_port = 4'($urandom);
                hold = int'($urandom_range(1, 2 * N + 2));
            end else begin
                hold--;
            end
            address = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
            end else begin
                chipselect = 1'($urandom); write_n = 1'b1; writedata = $urandom;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
